// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Used by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef logic [0:0] req_id_t;

    localparam int LAT_W = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Winner select between two requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last; otherwise m0 always wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_i,
    output logic       valid_o,
    output req_id_t    win_o
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last_s;
    assign unused_last_s = last_i[0];
`endif

    // Winner decode from the request pair
    always_comb begin
        valid_o = |req_i;
        win_o   = 1'b0;
        case (req_i)
            2'b01:   win_o = 1'b0;
            2'b10:   win_o = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            2'b11:   win_o = ~last_i;
`else
            2'b11:   win_o = 1'b0;
`endif
            default: win_o = 1'b0;
        endcase
    end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one access at a time, fixed read latency, req/gnt/rvalid handshake.
// MEM_ARB_ROUND_ROBIN_EN adds a last-winner pointer so ties alternate between requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 10,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    arb_state_e       state_q, state_d;
    req_id_t          id_q, id_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             en_q, en_d;
    logic             mem_we_q, mem_we_d;

    req_id_t          last_s;
    logic             pick_valid_s;
    req_id_t          pick_win_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_q;

    // Last-winner pointer; resets to 1 so m0 takes the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (state_q == ISSUE) begin
            last_q <= id_q;
        end else begin
            last_q <= last_q;
        end
    end

    assign last_s = last_q;
`else
    assign last_s = 1'b1;
`endif

    mem_arb_pick u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_s),
        .valid_o (pick_valid_s),
        .win_o   (pick_win_s)
    );

    // Access sequencer: latch winner, strobe memory, count latency, complete
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    id_d    = pick_win_s;
                    we_d    = (pick_win_s == 1'b1) ? m1_we    : m0_we;
                    addr_d  = (pick_win_s == 1'b1) ? m1_addr  : m0_addr;
                    wdata_d = (pick_win_s == 1'b1) ? m1_wdata : m0_wdata;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_W'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT_W'(0)) begin
                    if (!we_q) begin
                        if (id_q == 1'b1) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they appear registered in that state
        en_d      = (state_d == ISSUE);
        mem_we_d  = en_d && we_d;
        gnt0_d    = en_d && (id_d == 1'b0);
        gnt1_d    = en_d && (id_d == 1'b1);
        rvalid0_d = (state_d == DONE) && (id_d == 1'b0);
        rvalid1_d = (state_d == DONE) && (id_d == 1'b1);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            cnt_q     <= LAT_W'(0);
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            en_q      <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            en_q      <= en_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign mem_en    = en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses LATENCY=1, instance 1 uses LATENCY=4.
// Expected tie order follows MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic        req    [2][2];
    logic        we     [2][2];
    logic [9:0]  addr   [2][2];
    logic [31:0] wdata  [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdata  [2][2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];

    typedef struct {
        int          port;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          checks = 0;
    int          errors = 0;
    int          en_cyc [2];
    logic [31:0] exp_rd [2][2];

    function automatic logic [31:0] pattern(input logic [9:0] a);
        return (a == 10'h004) ? 32'hDEADBEEF : (32'hC0DE0000 | {22'd0, a});
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 4;
        logic [31:0] mem [1024];
        logic [L-1:0] vld;
        logic [31:0] pd [L];
        logic [31:0] rd_s;

        assign rd_s = vld[L-1] ? pd[L-1] : 32'hBAADF00D;

        mem_arbiter #(.AW(10), .LATENCY(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .m0_req    (req[g][0]),
            .m0_we     (we[g][0]),
            .m0_addr   (addr[g][0]),
            .m0_wdata  (wdata[g][0]),
            .m0_gnt    (gnt[g][0]),
            .m0_rvalid (rvalid[g][0]),
            .m0_rdata  (rdata[g][0]),
            .m1_req    (req[g][1]),
            .m1_we     (we[g][1]),
            .m1_addr   (addr[g][1]),
            .m1_wdata  (wdata[g][1]),
            .m1_gnt    (gnt[g][1]),
            .m1_rvalid (rvalid[g][1]),
            .m1_rdata  (rdata[g][1]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (rd_s)
        );

        // Memory model: data is presented only in the single cycle LATENCY after mem_en
        always @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < 1024; k++) mem[k] <= pattern(10'(k));
                vld <= '0;
            end else begin
                if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                for (int k = L - 1; k > 0; k--) begin
                    vld[k] <= vld[k-1];
                    pd[k]  <= pd[k-1];
                end
                vld[0] <= mem_en[g] && !mem_we[g];
                pd[0]  <= mem[mem_addr[g]];
            end
        end
    end

    task automatic push(input int i, input int p, input bit w, input logic [9:0] a,
                        input logic [31:0] d, input logic [31:0] r);
        exp_t e;
        e.port = p; e.we = w; e.addr = a; e.wdata = d; e.rdata = r;
        if (i == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic mon(input int i);
        exp_t e;
        bit   have;
        have = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (have) e = (i == 0) ? sb0[0] : sb1[0];
        if (mem_en[i]) begin
            if (!have) begin
                check_val("unexpected_issue", {31'd0, mem_en[i]}, 32'd0);
            end else begin
                check_val("issue_addr", {22'd0, mem_addr[i]}, {22'd0, e.addr});
                check_val("issue_we", {31'd0, mem_we[i]}, {31'd0, e.we});
                if (e.we) check_val("issue_wdata", mem_wdata[i], e.wdata);
                check_val("issue_gnt", {30'd0, gnt[i][1], gnt[i][0]}, (e.port == 1) ? 32'd2 : 32'd1);
                en_cyc[i] = cyc;
            end
        end else if (gnt[i][0] || gnt[i][1]) begin
            check_val("gnt_without_en", {30'd0, gnt[i][1], gnt[i][0]}, 32'd0);
        end
        if (rvalid[i][0] || rvalid[i][1]) begin
            if (!have) begin
                check_val("unexpected_rvalid", {30'd0, rvalid[i][1], rvalid[i][0]}, 32'd0);
            end else begin
                check_val("rvalid_port", {30'd0, rvalid[i][1], rvalid[i][0]}, (e.port == 1) ? 32'd2 : 32'd1);
                check_val("rvalid_cycle", 32'(cyc), 32'(en_cyc[i] + 1 + lat(i)));
                if (!e.we) exp_rd[i][e.port] = e.rdata;
                check_val("rdata_m0", rdata[i][0], exp_rd[i][0]);
                check_val("rdata_m1", rdata[i][1], exp_rd[i][1]);
                if (i == 0) void'(sb0.pop_front());
                else void'(sb1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic access(input int i, input int p, input bit w, input logic [9:0] a,
                          input logic [31:0] d, output int gc);
        we[i][p] = w; addr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
        gc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt[i][p]) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) check_val("gnt_timeout", {31'd0, gnt[i][p]}, 32'd1);
        @(posedge clk);
        #1;
        req[i][p] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb0.size() == 0 && sb1.size() == 0) break;
            @(negedge clk);
        end
        check_val("drain", 32'(sb0.size() + sb1.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int i, input string tag);
        check_val(tag, {26'd0, gnt[i][0], gnt[i][1], rvalid[i][0], rvalid[i][1], mem_en[i], mem_we[i]}, 32'd0);
        check_val({tag, "_addr"}, {22'd0, mem_addr[i]}, 32'd0);
        check_val({tag, "_wdata"}, mem_wdata[i], 32'd0);
        check_val({tag, "_rd0"}, rdata[i][0], 32'd0);
        check_val({tag, "_rd1"}, rdata[i][1], 32'd0);
    endtask

    int t0, g0a, g0b, g1, nrv;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = 10'd0; wdata[i][p] = 32'd0;
                exp_rd[i][p] = 32'd0;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset0");
        check_idle(1, "reset1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single read, LATENCY=1
        t0 = cyc;
        push(0, 0, 1'b0, 10'h004, 32'd0, 32'hDEADBEEF);
        access(0, 0, 1'b0, 10'h004, 32'd0, g0a);
        check_val("t1_gnt_cycle", 32'(g0a), 32'(t0 + 1));
        drain();

        // single write from m1, then read it back
        t0 = cyc;
        push(0, 1, 1'b1, 10'h010, 32'h12345678, 32'd0);
        access(0, 1, 1'b1, 10'h010, 32'h12345678, g1);
        check_val("t2_gnt_cycle", 32'(g1), 32'(t0 + 1));
        drain();
        push(0, 1, 1'b0, 10'h010, 32'd0, 32'h12345678);
        access(0, 1, 1'b0, 10'h010, 32'd0, g1);
        drain();

        // tie with both requests held
        t0 = cyc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push(0, 0, 1'b0, 10'h020, 32'd0, pattern(10'h020));
        push(0, 1, 1'b0, 10'h030, 32'd0, pattern(10'h030));
        push(0, 0, 1'b0, 10'h021, 32'd0, pattern(10'h021));
`else
        push(0, 0, 1'b0, 10'h020, 32'd0, pattern(10'h020));
        push(0, 0, 1'b0, 10'h021, 32'd0, pattern(10'h021));
        push(0, 1, 1'b0, 10'h030, 32'd0, pattern(10'h030));
`endif
        fork
            begin
                access(0, 0, 1'b0, 10'h020, 32'd0, g0a);
                access(0, 0, 1'b0, 10'h021, 32'd0, g0b);
            end
            begin
                access(0, 1, 1'b0, 10'h030, 32'd0, g1);
            end
        join
        check_val("t3_gnt_m0a", 32'(g0a), 32'(t0 + 1));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check_val("t3_gnt_m1", 32'(g1), 32'(t0 + 5));
        check_val("t3_gnt_m0b", 32'(g0b), 32'(t0 + 9));
`else
        check_val("t3_gnt_m0b", 32'(g0b), 32'(t0 + 5));
        check_val("t3_gnt_m1", 32'(g1), 32'(t0 + 9));
`endif
        drain();

        // LATENCY=4 read
        t0 = cyc;
        push(1, 0, 1'b0, 10'h033, 32'd0, pattern(10'h033));
        access(1, 0, 1'b0, 10'h033, 32'd0, g0a);
        check_val("t4_gnt_cycle", 32'(g0a), 32'(t0 + 1));
        drain();

        // reset pulse during WAIT drops the access
        push(1, 1, 1'b0, 10'h040, 32'd0, pattern(10'h040));
        access(1, 1, 1'b0, 10'h040, 32'd0, g1);
        #2;
        rst = 1'b1;
        #1;
        check_idle(1, "t5_async");
        sb0.delete();
        sb1.delete();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) exp_rd[i][p] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nrv = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid[1][0] || rvalid[1][1]) nrv++;
        end
        check_val("t5_no_rvalid", 32'(nrv), 32'd0);
        @(posedge clk);
        #1;
        t0 = cyc;
        push(1, 1, 1'b0, 10'h041, 32'd0, pattern(10'h041));
        access(1, 1, 1'b0, 10'h041, 32'd0, g1);
        check_val("t5_fresh_gnt", 32'(g1), 32'(t0 + 1));
        drain();

        // m1 request arriving during m0 WAIT
        t0 = cyc;
        push(0, 0, 1'b0, 10'h050, 32'd0, pattern(10'h050));
        push(0, 1, 1'b0, 10'h060, 32'd0, pattern(10'h060));
        fork
            begin
                access(0, 0, 1'b0, 10'h050, 32'd0, g0a);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                access(0, 1, 1'b0, 10'h060, 32'd0, g1);
            end
        join
        check_val("t6_gnt_m0", 32'(g0a), 32'(t0 + 1));
        check_val("t6_gnt_m1", 32'(g1), 32'(t0 + 5));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
